score_tick_gen: RTL

Generates the score-advance strobe `ScoreClock` that drives the four-digit scoreboard. It is clocked by the system clock and gated by game state (start/collision). The tick interval shortens as the score grows. It also emits a one-cycle `scoreRst` pulse on every new game, plus a level and point count for obstacle-speed and high-score logic. It sits directly upstream of the scoreboard renderer: `ScoreClock`/`scoreRst` feed its clock/reset-style inputs.

---
 rtl/score_tick_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/score_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : score_tick_gen
// Description : Score-advance strobe generator. Emits one ScoreClock pulse per
//               point, with the interval shrinking as the level rises.
// Revision    : 1.0 - initial release
// ============================================================================
module score_tick_gen #(
    parameter int unsigned BASE_PERIOD  = 2500000,
    parameter int unsigned MIN_PERIOD   = 1000000,
    parameter int unsigned PERIOD_STEP  = 250000,
    parameter int unsigned LEVEL_POINTS = 100,
    parameter int unsigned MAX_LEVEL    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        collide,
    output logic        ScoreClock,
    output logic        scoreRst,
    output logic        running,
    output logic [3:0]  level,
    output logic [13:0] points
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [31:0] c_base       = BASE_PERIOD;
    localparam logic [31:0] c_min        = MIN_PERIOD;
    localparam logic [31:0] c_step       = PERIOD_STEP;
    localparam logic [31:0] c_lvl_last   = LEVEL_POINTS - 1;
    localparam logic [31:0] c_max_level32 = MAX_LEVEL;
    localparam logic [3:0]  c_max_level  = c_max_level32[3:0];
    localparam logic [13:0] c_max_points = 14'd9999;

    logic [1:0]  r_state,   w_state_nxt;
    logic [31:0] r_divider, w_divider_nxt;
    logic [31:0] r_period,  w_period_nxt;
    logic [31:0] r_pil,     w_pil_nxt;
    logic [3:0]  r_level,   w_level_nxt;
    logic [13:0] r_points,  w_points_nxt;
    logic        r_tick,    w_tick_nxt;
    logic        r_srst,    w_srst_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_divider <= '0;
            r_period  <= c_base;
            r_pil     <= '0;
            r_level   <= '0;
            r_points  <= '0;
            r_tick    <= 1'b0;
            r_srst    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_divider <= w_divider_nxt;
            r_period  <= w_period_nxt;
            r_pil     <= w_pil_nxt;
            r_level   <= w_level_nxt;
            r_points  <= w_points_nxt;
            r_tick    <= w_tick_nxt;
            r_srst    <= w_srst_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_divider_nxt = r_divider;
        w_period_nxt  = r_period;
        w_pil_nxt     = r_pil;
        w_level_nxt   = r_level;
        w_points_nxt  = r_points;
        w_tick_nxt    = 1'b0;
        w_srst_nxt    = 1'b0;

        case (r_state)
            S_RUN: begin
                // Collision wins over a coincident tick: no point is scored.
                if (collide) begin
                    w_state_nxt = S_DEAD;
                end else if (r_divider == r_period - 32'd1) begin
                    w_divider_nxt = '0;
                    w_tick_nxt    = 1'b1;
                    w_points_nxt  = (r_points == c_max_points) ? 14'd0 : r_points + 14'd1;
                    if (r_pil == c_lvl_last) begin
                        w_pil_nxt = '0;
                        if (r_level < c_max_level)
                            w_level_nxt = r_level + 4'd1;
                        // Compare before subtracting so the period never underflows.
                        w_period_nxt = (r_period >= c_min + c_step) ? r_period - c_step : c_min;
                    end else begin
                        w_pil_nxt = r_pil + 32'd1;
                    end
                end else begin
                    w_divider_nxt = r_divider + 32'd1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_srst_nxt    = 1'b1;
                    w_divider_nxt = '0;
                    w_points_nxt  = '0;
                    w_pil_nxt     = '0;
                    w_level_nxt   = '0;
                    w_period_nxt  = c_base;
                end
            end
        endcase
    end

    assign ScoreClock = r_tick;
    assign scoreRst   = r_srst;
    assign running    = (r_state == S_RUN);
    assign level      = r_level;
    assign points     = r_points;

endmodule
`default_nettype wire
